// File: rtl/arb_pkg.sv
// Shared types for the arbiter requester agent: FSM state encoding and beat layout.
package arb_pkg;

    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_req_state_e;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] data;
        logic                  last;
    } arb_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port and wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Both flags come straight from the pointer registers, so a pop never frees a slot for a same-cycle push.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/arb_requester.sv
// Requester agent in front of one round-robin arbiter input: buffers packets and
// streams exactly one complete packet per grant.
module arb_requester
    import arb_pkg::*;
#(
    parameter  int DATA_W = ARB_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              req,
    input  logic              grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  pkt_pending,
    output logic              grant_err
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    // Handshakes: a beat moves on a rising clk edge where valid and ready are both high;
    // valid never depends on ready, and ready never waits for valid.

    arb_req_state_e state;
    arb_req_state_e next_state;

    beat_t fifo_in;
    beat_t fifo_out;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  pop;

    assign in_ready = rst_n && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign fifo_in.data = in_data;
    assign fifo_in.last = in_last;

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_in),
        .pop   (pop),
        .rdata (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data  = fifo_out.data;
    assign out_last  = fifo_out.last;
    assign out_valid = (state == XFER) && grant && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_pending <= '0;
        end else begin
            case ({push && in_last, pop && out_last})
                2'b10:   pkt_pending <= pkt_pending + CNT_W'(1);
                2'b01:   pkt_pending <= pkt_pending - CNT_W'(1);
                default: pkt_pending <= pkt_pending;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            // Arbiter clears grant a cycle after req falls; never re-request until it has.
            IDLE:    if (pkt_pending != '0 && !grant) next_state = REQ;
            REQ:     if (grant) next_state = XFER;
            XFER:    if (pop && out_last) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            state <= next_state;
            req   <= (next_state == REQ) || (next_state == XFER);
            if (state == XFER && !grant) begin
                grant_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: cycle table for the basic packet, scripted
// sequences with a registered-arbiter model and a beat scoreboard for the rest.
module tb_arb_requester;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              req;
    logic              grant = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [CNT_W-1:0]  pkt_pending;
    logic              grant_err;

    arb_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .req         (req),
        .grant       (grant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .pkt_pending (pkt_pending),
        .grant_err   (grant_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W:0] exp_q[$];
    logic            auto_grant = 1'b1;
    logic            drop_grant = 1'b0;
    logic            mon_en = 1'b0;
    logic            last_req = 1'b0;
    logic            mon_prev_req = 1'b0;
    int              req_rises = 0;
    int              sent_cnt = 0;
    int              last_cnt = 0;

    typedef struct packed {
        logic              iv;
        logic [DATA_W-1:0] id;
        logic              il;
        logic              e_in_ready;
        logic              e_req;
        logic              e_out_valid;
        logic [DATA_W-1:0] e_out_data;
        logic              e_out_last;
        logic [CNT_W-1:0]  e_pend;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic iv, logic [DATA_W-1:0] id, logic il, logic eir, logic erq,
                                logic eov, logic [DATA_W-1:0] eod, logic eol, logic [CNT_W-1:0] ep);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il;
        v.e_in_ready = eir; v.e_req = erq; v.e_out_valid = eov;
        v.e_out_data = eod; v.e_out_last = eol; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample DUT outputs at the falling edge and run the scoreboard.
    task automatic sample();
        @(negedge clk);
        last_req = req;
        if (mon_en) begin
            if (out_valid) chk("out_valid_needs_grant", {63'd0, grant}, 64'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'd0, out_last, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("out_beat", {31'd0, out_last, out_data}, {31'd0, exp_q.pop_front()});
                end
                sent_cnt++;
                if (out_last) last_cnt++;
            end
            if (req && !mon_prev_req) begin
                req_rises++;
                chk("req_rise_grant_low", {63'd0, grant}, 64'd0);
            end
        end
        mon_prev_req = req;
    endtask

    // Registered arbiter model: grant follows req one cycle later unless forced low.
    task automatic advance();
        @(posedge clk);
        #1;
        if (auto_grant) grant = last_req && !drop_grant;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        advance();
        sample();
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pend", {59'd0, pkt_pending}, 64'd0);
        chk("rst_grant_err", {63'd0, grant_err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        advance();
        rst_n = 1'b1;
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic l);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        exp_q.push_back({l, d});
        while (!acc && n < 200) begin
            sample();
            acc = in_ready;
            advance();
            n++;
        end
        in_valid = 1'b0;
        chk("push_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic push_pkt(input int len, input logic [DATA_W-1:0] base);
        for (int i = 0; i < len; i++) push_beat(base + DATA_W'(i), (i == len - 1));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || req) && n < 2000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        out_ready = 1'b1;
        chk("drain_timeout", {63'd0, n >= 2000}, 64'd0);
        cycle();
        cycle();
    endtask

    initial begin
        tbl[0]  = mk(1, 32'hA0A0_0001, 0, 1, 0, 0, 32'h0, 0, 0);
        tbl[1]  = mk(1, 32'hA0A0_0002, 0, 1, 0, 0, 32'h0, 0, 0);
        tbl[2]  = mk(1, 32'hA0A0_0003, 1, 1, 0, 0, 32'h0, 0, 0);
        tbl[3]  = mk(0, 32'h0,         0, 1, 0, 0, 32'h0, 0, 1);
        tbl[4]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0, 0, 1);
        tbl[5]  = mk(0, 32'h0,         0, 1, 1, 0, 32'h0, 0, 1);
        tbl[6]  = mk(0, 32'h0,         0, 1, 1, 1, 32'hA0A0_0001, 0, 1);
        tbl[7]  = mk(0, 32'h0,         0, 1, 1, 1, 32'hA0A0_0002, 0, 1);
        tbl[8]  = mk(0, 32'h0,         0, 1, 1, 1, 32'hA0A0_0003, 1, 1);
        tbl[9]  = mk(0, 32'h0,         0, 1, 0, 0, 32'h0, 0, 0);
        tbl[10] = mk(0, 32'h0,         0, 1, 0, 0, 32'h0, 0, 0);
        tbl[11] = mk(0, 32'h0,         0, 1, 0, 0, 32'h0, 0, 0);

        do_reset();

        // Basic 3-beat packet, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].iv;
            in_data  = tbl[i].id;
            in_last  = tbl[i].il;
            sample();
            chk($sformatf("t1_in_ready[%0d]", i), {63'd0, in_ready}, {63'd0, tbl[i].e_in_ready});
            chk($sformatf("t1_req[%0d]", i), {63'd0, req}, {63'd0, tbl[i].e_req});
            chk($sformatf("t1_out_valid[%0d]", i), {63'd0, out_valid}, {63'd0, tbl[i].e_out_valid});
            chk($sformatf("t1_pend[%0d]", i), {59'd0, pkt_pending}, {59'd0, tbl[i].e_pend});
            if (tbl[i].e_out_valid) begin
                chk($sformatf("t1_out_data[%0d]", i), {32'd0, out_data}, {32'd0, tbl[i].e_out_data});
                chk($sformatf("t1_out_last[%0d]", i), {63'd0, out_last}, {63'd0, tbl[i].e_out_last});
            end
            advance();
        end
        in_valid = 1'b0;
        mon_en = 1'b1;

        // Two 2-beat packets: two separate req pulses.
        req_rises = 0;
        push_pkt(2, 32'hB000_0010);
        push_pkt(2, 32'hB000_0020);
        drain(1'b0);
        chk("t2_req_rises", 64'(req_rises), 64'd2);
        chk("t2_pend", {59'd0, pkt_pending}, 64'd0);

        // Full-depth packet.
        push_pkt(DEPTH, 32'hC000_0100);
        sample();
        chk("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t3_pend", {59'd0, pkt_pending}, 64'd1);
        advance();
        last_cnt = 0;
        drain(1'b0);
        chk("t3_last_cnt", 64'(last_cnt), 64'd1);
        chk("t3_in_ready_back", {63'd0, in_ready}, 64'd1);

        // Grant lost after beat 2 of 5.
        push_pkt(5, 32'hD000_0200);
        sent_cnt = 0;
        for (int n = 0; n < 100 && sent_cnt < 2; n++) cycle();
        chk("t4_sent_before_drop", 64'(sent_cnt), 64'd2);
        chk("t4_err_before", {63'd0, grant_err}, 64'd0);
        drop_grant = 1'b1;
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t4_gap_out_valid", {63'd0, out_valid}, 64'd0);
            chk("t4_gap_req", {63'd0, req}, 64'd1);
            advance();
        end
        chk("t4_grant_err", {63'd0, grant_err}, 64'd1);
        drop_grant = 1'b0;
        drain(1'b0);
        chk("t4_sent_total", 64'(sent_cnt), 64'd5);
        chk("t4_err_sticky", {63'd0, grant_err}, 64'd1);

        // Four packets drained with random back-pressure.
        last_cnt = 0;
        push_pkt(3, 32'hE000_0300);
        push_pkt(1, 32'hE000_0400);
        push_pkt(4, 32'hE000_0500);
        push_pkt(2, 32'hE000_0600);
        drain(1'b1);
        chk("t5_last_cnt", 64'(last_cnt), 64'd4);
        chk("t5_pend", {59'd0, pkt_pending}, 64'd0);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a transfer.
        push_pkt(4, 32'hF000_0700);
        sent_cnt = 0;
        for (int n = 0; n < 100 && sent_cnt < 1; n++) cycle();
        chk("t6_sent_before_rst", 64'(sent_cnt), 64'd1);
        rst_n = 1'b0;
        advance();
        mon_en = 1'b0;
        sample();
        chk("t6_req", {63'd0, req}, 64'd0);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_pend", {59'd0, pkt_pending}, 64'd0);
        chk("t6_grant_err", {63'd0, grant_err}, 64'd0);
        chk("t6_in_ready_in_rst", {63'd0, in_ready}, 64'd0);
        advance();
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t6_post_req", {63'd0, req}, 64'd0);
            chk("t6_post_out_valid", {63'd0, out_valid}, 64'd0);
            advance();
        end
        mon_en = 1'b1;
        last_cnt = 0;
        push_pkt(1, 32'h1234_5678);
        drain(1'b0);
        chk("t6_fresh_last", 64'(last_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the shared N-input round-robin arbiter (req/grant, grant held while req stays high).
- Buffers packetised beats from a local producer in an internal FIFO.
- Raises req once at least one complete packet is buffered, streams exactly one packet per grant, then releases req.
- One instance sits in front of each arbiter input; one arbiter grant bit drives each instance.

Parameters:
- DATA_W, 32, beat data width
- DEPTH, 16, FIFO depth in beats; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of packet/occupancy counters (derived, not overridden)

Ports:
- clk  input  1  clock, all logic posedge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  producer beat valid
- in_ready  output  1  FIFO can accept a beat (not full)
- in_data  input  DATA_W  producer beat data
- in_last  input  1  marks final beat of a packet
- req  output  1  request to arbiter
- grant  input  1  this agent's grant bit from arbiter (registered there)
- out_valid  output  1  beat valid toward shared datapath
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_W  beat data
- out_last  output  1  final beat of the packet
- pkt_pending  output  CNT_W  complete packets currently buffered
- grant_err  output  1  sticky: grant lost mid-packet

Behaviour:
- Reset (rst_n low at posedge): FIFO emptied, pkt_pending=0, state IDLE, req=0, out_valid=0, grant_err=0. in_ready=0 while rst_n low. A mid-packet reset discards the partial packet; no out_last is emitted.
- Input accept: beat accepted when in_valid & in_ready. in_ready = ~full.
- pkt_pending: +1 on an accepted beat with in_last, -1 on a sent beat with out_last, unchanged when both happen in the same cycle.
- Output handshake: beat sent when out_valid & out_ready.
- States:
  - IDLE: req=0. Go to REQ when pkt_pending != 0 and grant == 0.
  - REQ: req=1. Go to XFER when grant == 1.
  - XFER: req=1. out_valid = grant & ~empty. out_data/out_last come from FIFO head. On a sent beat with out_last, go to RELEASE.
  - RELEASE: req=0 for exactly one cycle, then IDLE.
- req is registered and derived only from state, never from grant combinationally.
- Re-request rule: req must not rise while grant is still high. IDLE waits for grant==0, because the arbiter clears grant one cycle after req drops.
- The FIFO never holds more than DEPTH beats. A packet longer than DEPTH deadlocks by design; the producer guarantees packet length <= DEPTH.
- Grant loss: if grant==0 while in XFER, then:
  - out_valid is forced 0
  - grant_err is set (sticky until reset)
  - state stays in XFER, holding req
  - transfer resumes on the next grant without losing or duplicating beats
- Simultaneous push and pop on a full FIFO: the pop frees a slot, but in_ready stays 0 that cycle (registered full). Simultaneous push and pop on an empty FIFO: no bypass, the beat appears at the output the next cycle.
- Pointers are log2(DEPTH) bits plus one wrap bit. full = same index with differing wrap bit.
- Latency:
  - Minimum from in_last accepted to req high: 2 cycles.
  - From grant high to first out_valid: 0 cycles (same cycle grant is seen in XFER).

Decomposition:
- Package arb_pkg:
  - typedef enum arb_req_state_e {IDLE, REQ, XFER, RELEASE}
  - beat struct {data, last}
- Sub-module sync_fifo (width DATA_W+1, depth DEPTH):
  - synchronous active-low reset
  - push/pop/full/empty interface
  - first-word-fall-through output
- FSM and counters live in arb_requester.

Test Plan:
- Reset, then push a 3-beat packet (A,B,C, last on C) with grant tied to req delayed by 1 cycle -> req high 2 cycles after C accepted; out emits A,B,C with out_last on C; req low the cycle after C; pkt_pending returns to 0.
- Push 2 packets of 2 beats, out_ready=1, arbiter model re-grants -> two separate req pulses with at least one low cycle between them; req not raised again until grant drops.
- Fill 16 beats in one packet (DEPTH=16) -> in_ready=0 at 16 beats; after grant, drain 16 beats with out_last on the 16th; in_ready returns to 1.
- In XFER, drop grant for 3 cycles after beat 2 of 5 -> out_valid=0 during the gap; grant_err=1; beats 3-5 follow on re-grant with no loss.
- Toggle out_ready randomly 50% across 4 packets -> data order preserved, exactly 4 out_last beats, pkt_pending ends at 0.
- Assert rst_n=0 mid-packet in XFER -> next cycle req=0, out_valid=0, pkt_pending=0, grant_err=0, FIFO empty.
